spi_rx_fsm: RTL and testbench
=============================

# spi_rx_fsm

SPI receiver (slave side) for the serial link driven by the team's SPI transmitter FSM. The block oversamples the cs_n/sclk/mosi lines with the 100 MHz system clock and deserialises one WIDTH-bit word per chip-select frame, SPI mode 0, MSB first. It presents each word with a single-cycle valid strobe and flags malformed frames. It is used as a loopback checker for the DAC link and as the front end of on-board SPI configuration slaves.

## Interface

- `WIDTH`, 16: bits per frame; also the width of `rx_data`. Legal range 2–32.
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  synchronous, active-high reset.
- `cs_n`  in  1  chip select, active low, asynchronous to `clk`.
- `sclk`  in  1  serial clock, idle low (CPOL=0), asynchronous to `clk`.
- `mosi`  in  1  serial data, MSB first, stable around `sclk` rising edges.
- `rx_data`  out  WIDTH  last complete word; held until the next complete word.
- `rx_valid`  out  1  one-cycle pulse; `rx_data` is new in that cycle.
- `busy`  out  1  high while a frame is open (state not IDLE).
- `frame_err`  out  1  one-cycle pulse on a malformed frame (see Configuration).

## Operation

- Synchroniser: `cs_n`, `sclk` and `mosi` each pass through two flops, plus a third delay flop on `cs_n` and `sclk` for edge detection. On reset, the `cs_n` stages load 0 and the `sclk`/`mosi` stages load 0.
- Events, all from synchronised copies: `cs_fall` (s2=0, s3=1), `cs_rise` (s2=1, s3=0), `sclk_rise` (s2=1, s3=0). `mosi` is taken from its s2 stage.
- Bit counter: `$clog2(WIDTH+1)` bits. Shift register: WIDTH bits, shifting left with the new bit in LSB.
- States:
  - IDLE:
    - `cs_fall` → SHIFT, clear the counter and the overrun flag.
    - All `sclk` activity is ignored.
  - SHIFT:
    - `sclk_rise` shifts in `mosi` and increments the counter.
    - On the WIDTH-th `sclk_rise`, load `rx_data` from {shift[WIDTH-2:0], mosi}, pulse `rx_valid`, and go to HOLD.
    - `cs_rise` before the WIDTH-th bit (short frame) → IDLE. Pulse `frame_err`; no `rx_valid`; `rx_data` is unchanged.
  - HOLD:
    - `sclk_rise` sets the overrun flag.
    - `cs_rise` → IDLE. If overrun is set, pulse `frame_err`.
- Simultaneous events:
  - `cs_rise` and `sclk_rise` in the same cycle in SHIFT: the `cs_rise` wins and the bit is discarded.
  - `cs_fall` always wins in IDLE.
- Reset:
  - `rst` takes priority over every event.
  - After reset: state IDLE, counter 0, shift register 0, `rx_data` = 0, `rx_valid` = 0, `busy` = 0, `frame_err` = 0, overrun flag cleared.
- Reset mid-frame:
  - The partial word is dropped.
  - Because the `cs_n` sync stages reset to 0, a frame still open at reset release produces no `cs_fall`. The block therefore stays in IDLE until `cs_n` goes high and then low again; no spurious word or error is produced.
- `busy` = (state != IDLE), registered with the state.

## Timing

- Input constraints: `sclk` high and low phases ≥ 3 clk cycles each (sclk ≤ 16.6 MHz). `cs_n` fall to first `sclk` rise ≥ 3 clk cycles. Last `sclk` rise to `cs_n` rise ≥ 3 clk cycles. `mosi` setup/hold around `sclk` rise ≥ 3 clk cycles.
- Latency, for an input edge occurring between clk edges k and k+1:
  - The event is decoded in the cycle after edge k+2.
  - The register update lands on edge k+3.
  - `rx_valid` is high from edge k+3 to edge k+4, relative to the WIDTH-th `sclk` rise.
- `busy` rises at edge k+3 after the `cs_n` fall and drops at edge k+3 after the `cs_n` rise.
- `frame_err` pulses at edge k+3 after the offending `cs_n` rise.
- Back-to-back frames: a new `cs_fall` is accepted the cycle after IDLE is entered. The minimum `cs_n` high time is 3 clk cycles.

## Configuration

- `SPI_RX_FRAME_CHECK_EN` defined:
  - Overrun flag, short-frame detection and the `frame_err` pulse are compiled in as described above.
- `SPI_RX_FRAME_CHECK_EN` undefined:
  - The overrun flag is removed and `frame_err` is tied to 0.
  - Short frames are still dropped silently (→ IDLE, no `rx_valid`).
  - Extra `sclk` edges in HOLD are ignored.
  - All other behaviour and timing are identical.

## Test plan

- Frame 16'hABCD, 16 sclk at 5 MHz, driven by the team's SPI transmitter FSM from the same 100 MHz ClockGen → one `rx_valid` pulse; `rx_data` = 16'hABCD; `frame_err` = 0; `busy` high for the frame and 0 at least 3 clk after the `cs_n` rise.
- Back-to-back frames 16'hABCD then 16'h1234, with `cs_n` high for 3 clk cycles between them → two `rx_valid` pulses, with `rx_data` = 16'hABCD then 16'h1234.
- Short frame of 8 bits (0xFF) then `cs_n` high, after a prior 16'hABCD → no `rx_valid`; `frame_err` pulses once; `rx_data` stays 16'hABCD.
- 17-bit frame 16'h5A5A plus an extra bit → `rx_valid` after the 16th bit with `rx_data` = 16'h5A5A; `frame_err` pulses once 3 clk after the `cs_n` rise.
- `rst` asserted after 5 bits of a frame and released while `cs_n` is still low; the remaining 11 bits are sent → no `rx_valid` and no `frame_err`. The next full frame 16'hC3C3 is received correctly.
- Macro undefined: repeat the short-frame and 17-bit cases → `frame_err` stays 0. The 17-bit case still yields `rx_data` = 16'h5A5A.

Source files
------------

// File: rtl/spi_rx_fsm.sv
// rtl/spi_rx_fsm.sv - SPI mode 0 slave receiver, one WIDTH-bit word per cs_n frame
// Optional frame checking (overrun/short-frame frame_err) under `SPI_RX_FRAME_CHECK_EN.
module spi_rx_fsm #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs_n,
  input  logic             sclk,
  input  logic             mosi,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // cs_n stages reset to 0 so a frame still open at reset release yields no cs_fall
  logic cs_s1, cs_s2, cs_s3;
  logic sclk_s1, sclk_s2, sclk_s3;
  logic mosi_s1, mosi_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_s1   <= 1'b0;
      cs_s2   <= 1'b0;
      cs_s3   <= 1'b0;
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      cs_s1   <= cs_n;
      cs_s2   <= cs_s1;
      cs_s3   <= cs_s2;
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  logic cs_fall, cs_rise, sclk_rise;
  assign cs_fall   = ~cs_s2 & cs_s3;
  assign cs_rise   = cs_s2 & ~cs_s3;
  assign sclk_rise = sclk_s2 & ~sclk_s3;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q;
  logic [WIDTH-1:0]  shift_next;

  assign shift_next = {shift_q[WIDTH-2:0], mosi_s2};

`ifdef SPI_RX_FRAME_CHECK_EN
  logic ovr_q, ovr_d;
  logic err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
`ifdef SPI_RX_FRAME_CHECK_EN
    ovr_d   = ovr_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          cnt_d   = '0;
`ifdef SPI_RX_FRAME_CHECK_EN
          ovr_d   = 1'b0;
`endif
        end
      end
      SHIFT: begin
        // cs_rise wins over a coincident sclk_rise; that bit is discarded
        if (cs_rise) begin
          state_d = IDLE;
`ifdef SPI_RX_FRAME_CHECK_EN
          err_d   = 1'b1;
`endif
        end else if (sclk_rise) begin
          shift_d = shift_next;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            data_d  = shift_next;
            valid_d = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (cs_rise) begin
          state_d = IDLE;
`ifdef SPI_RX_FRAME_CHECK_EN
          err_d   = ovr_q;
`endif
        end
`ifdef SPI_RX_FRAME_CHECK_EN
        else if (sclk_rise) begin
          ovr_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SPI_RX_FRAME_CHECK_EN
      ovr_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= (state_d != IDLE);
`ifdef SPI_RX_FRAME_CHECK_EN
      ovr_q   <= ovr_d;
      err_q   <= err_d;
`endif
    end
  end

  assign rx_data  = data_q;
  assign rx_valid = valid_q;
  assign busy     = busy_q;
`ifdef SPI_RX_FRAME_CHECK_EN
  assign frame_err = err_q;
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_rx_fsm.sv
// tb/tb_spi_rx_fsm.sv - scoreboard bench for spi_rx_fsm (expects `SPI_RX_FRAME_CHECK_EN to match the DUT build)
module tb_spi_rx_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs_n;
  logic        sclk;
  logic        mosi;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        busy;
  logic        frame_err;

  spi_rx_fsm #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cs_n      (cs_n),
    .sclk      (sclk),
    .mosi      (mosi),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

`ifdef SPI_RX_FRAME_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  int valid_seen = 0;
  int err_seen   = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: every rx_valid pops one expected word
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (rx_valid === 1'b1) begin
        valid_seen++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got rx_data %h expected no word", rx_data);
        end else begin
          chk("rx_word", {16'h0, rx_data}, {16'h0, exp_q.pop_front()});
        end
      end
      if (frame_err === 1'b1) err_seen++;
    end
  end

  // sclk at 5 MHz: 10 clk per phase
  task automatic send_bits(input logic [31:0] v, input int n, input logic open_cs,
                           input logic exp_busy, input string name);
    if (open_cs) begin
      @(negedge clk);
      cs_n = 1'b0;
    end
    repeat (10) @(negedge clk);
    chk({name, "_busy"}, {31'h0, busy}, {31'h0, exp_busy});
    for (int i = n - 1; i >= 0; i--) begin
      mosi = v[i];
      repeat (10) @(negedge clk);
      sclk = 1'b1;
      repeat (10) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic cs_up(input logic exp_busy_before, input logic exp_err, input string name);
    @(negedge clk);
    cs_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk({name, "_busy_pre"}, {31'h0, busy}, {31'h0, exp_busy_before});
    chk({name, "_err_pre"}, {31'h0, frame_err}, 32'h0);
    @(posedge clk);
    #1;
    chk({name, "_busy_post"}, {31'h0, busy}, 32'h0);
    chk({name, "_err_post"}, {31'h0, frame_err}, {31'h0, exp_err});
  endtask

  initial begin
    rst  = 1'b1;
    cs_n = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_data", {16'h0, rx_data}, 32'h0);
    chk("reset_valid", {31'h0, rx_valid}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_err", {31'h0, frame_err}, 32'h0);

    // single frame, then back-to-back with 3 clk cs_n high
    exp_q.push_back(16'hABCD);
    send_bits(32'hABCD, 16, 1'b1, 1'b1, "f_abcd");
    cs_up(1'b1, 1'b0, "f_abcd");
    exp_q.push_back(16'h1234);
    send_bits(32'h1234, 16, 1'b1, 1'b1, "f_1234");
    cs_up(1'b1, 1'b0, "f_1234");
    chk("b2b_data", {16'h0, rx_data}, 32'h1234);
    chk("b2b_count", valid_seen, 2);

    // short frame after ABCD
    repeat (5) @(negedge clk);
    exp_q.push_back(16'hABCD);
    send_bits(32'hABCD, 16, 1'b1, 1'b1, "f_abcd2");
    cs_up(1'b1, 1'b0, "f_abcd2");
    send_bits(32'hFF, 8, 1'b1, 1'b1, "short");
    cs_up(1'b1, CHK, "short");
    chk("short_keep", {16'h0, rx_data}, 32'hABCD);
    chk("short_count", valid_seen, 3);

    // 17-bit frame: word after 16th bit, overrun on the 17th
    repeat (5) @(negedge clk);
    exp_q.push_back(16'h5A5A);
    send_bits({15'h0, 16'h5A5A, 1'b1}, 17, 1'b1, 1'b1, "long");
    cs_up(1'b1, CHK, "long");
    chk("long_data", {16'h0, rx_data}, 32'h5A5A);

    // reset mid-frame, released with cs_n still low
    repeat (5) @(negedge clk);
    send_bits(32'h1F, 5, 1'b1, 1'b1, "rst_mid");
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_data", {16'h0, rx_data}, 32'h0);
    send_bits(32'h7FF, 11, 1'b0, 1'b0, "rst_rest");
    cs_up(1'b0, 1'b0, "rst_rest");
    chk("rst_mid_count", valid_seen, 4);
    repeat (5) @(negedge clk);
    exp_q.push_back(16'hC3C3);
    send_bits(32'hC3C3, 16, 1'b1, 1'b1, "f_c3c3");
    cs_up(1'b1, 1'b0, "f_c3c3");
    chk("c3c3_data", {16'h0, rx_data}, 32'hC3C3);

    repeat (10) @(negedge clk);
    chk("valid_total", valid_seen, 5);
    chk("err_total", err_seen, CHK ? 2 : 0);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
